// File: rtl/alu_seq.sv
// Command sequencer: a 4-entry command FIFO feeds an IDLE/EXEC/OUT controller that
// drives an external combinational ALU and keeps a 4-bit accumulator as the result.
module alu_seq #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_data,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [4:0] alu_f,
  input  logic [3:0] alu_y,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic       res_zero
);

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_AND = 3'd3,
    OP_OR   = 3'd4, OP_SHR = 3'd5, OP_SHL = 3'd6, OP_CLR = 3'd7
  } op_e;

  typedef struct packed {
    op_e        op;
    logic [3:0] data;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;

  localparam logic [4:0] F_IDLE = 5'b11111;

  cmd_t       mem [FIFO_DEPTH];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       push, pop;

  state_t     state, state_nxt;
  cmd_t       ir;
  logic [3:0] acc, acc_nxt;

  // Ready comes only from the registered count, never from cmd_valid.
  assign cmd_ready = count < 3'(FIFO_DEPTH);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (count != 3'd0);

  function automatic logic [4:0] alu_fn(input op_e op);
    case (op)
      OP_ADD:  return 5'b00010;
      OP_SUB:  return 5'b00011;
      OP_AND:  return 5'b01000;
      OP_OR:   return 5'b01100;
      OP_SHR:  return 5'b00000;
      OP_SHL:  return 5'b10000;
      default: return F_IDLE;
    endcase
  endfunction

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: op_e'(cmd_op), data: cmd_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    alu_a     = acc;
    alu_b     = '0;
    alu_f     = F_IDLE;
    case (state)
      IDLE: if (count != 3'd0) state_nxt = EXEC;
      EXEC: begin
        state_nxt = OUT;
        case (ir.op)
          OP_LOAD: acc_nxt = ir.data;
          OP_CLR:  acc_nxt = '0;
          default: begin
            alu_b   = ir.data;
            alu_f   = alu_fn(ir.op);
            acc_nxt = alu_y;
          end
        endcase
      end
      OUT:     if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      if (pop) ir <= mem[rd_ptr];
    end
  end

  assign res_valid = (state == OUT);
  assign res_data  = acc;
  assign res_zero  = (acc == 4'd0);

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: models the external ALU, predicts results from accepted
// commands with plain modulo-16 arithmetic, and checks directed and random traffic.
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [3:0] cmd_data = '0;
  logic [3:0] alu_a, alu_b, alu_y;
  logic [4:0] alu_f;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_data;
  logic       res_zero;

  int checks = 0;
  int failures = 0;

  logic [3:0] exp_q [$];
  logic [4:0] got_q [$];
  logic [8:0] alu_q [$];
  logic [3:0] m_acc = '0;

  always #5 clk = ~clk;

  alu_seq #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_f(alu_f), .alu_y(alu_y), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero)
  );

  // External combinational ALU.
  always_comb begin
    alu_y = 4'h0;
    case (alu_f)
      5'b00010: alu_y = alu_a + alu_b;
      5'b00011: alu_y = alu_a - alu_b;
      5'b01000: alu_y = alu_a & alu_b;
      5'b01100: alu_y = alu_a | alu_b;
      5'b00000: alu_y = alu_a >> 1;
      5'b10000: alu_y = alu_a << 1;
      default:  alu_y = 4'h0;
    endcase
  end

  function automatic logic [3:0] ref_step(input logic [3:0] acc, input logic [2:0] op,
                                          input logic [3:0] d);
    int a = int'(acc);
    int b = int'(d);
    int r;
    case (op)
      3'd0:    r = b;
      3'd1:    r = a + b;
      3'd2:    r = a - b + 16;
      3'd3:    r = a & b;
      3'd4:    r = a | b;
      3'd5:    r = a / 2;
      3'd6:    r = a * 2;
      default: r = 0;
    endcase
    return 4'(r % 16);
  endfunction

  // Observe handshakes away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      got_q.delete();
      alu_q.delete();
      m_acc = '0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        m_acc = ref_step(m_acc, cmd_op, cmd_data);
        exp_q.push_back(m_acc);
      end
      if (res_valid && res_ready) got_q.push_back({res_zero, res_data});
      if (alu_f != 5'b11111) alu_q.push_back({alu_f, alu_a});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] d);
    int k = 0;
    cmd_op = op;
    cmd_data = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && k < 50) begin
      tick();
      k++;
    end
    checks++;
    if (!cmd_ready) begin
      failures++;
      $display("FAIL send_timeout op=%0d data=%0d cmd_ready=%0b required=1", op, d, cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int k = 0;
    while (got_q.size() < n && k < 300) begin
      tick();
      k++;
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    tick();
    tick();
    checks++;
    if ({res_valid, res_data, res_zero, cmd_ready, alu_f, alu_a, alu_b} !==
        {1'b0, 4'h0, 1'b1, 1'b1, 5'h1f, 4'h0, 4'h0}) begin
      failures++;
      $display("FAIL reset_outputs got v=%0b d=%0d z=%0b rdy=%0b f=%b a=%0d b=%0d required v=0 d=0 z=1 rdy=1 f=11111 a=0 b=0",
               res_valid, res_data, res_zero, cmd_ready, alu_f, alu_a, alu_b);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    logic [3:0] v [3] = '{4'd7, 4'd12, 4'd5};
    exp_q.delete(); got_q.delete();
    res_ready = 1'b1;
    send(3'd0, 4'd7);
    send(3'd1, 4'd5);
    send(3'd1, 4'd9);
    wait_got(3);
    checks++;
    if (got_q.size() != 3) begin
      failures++;
      $display("FAIL add_count got=%0d required=3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i] !== {1'b0, v[i]}) begin
          failures++;
          $display("FAIL add_result[%0d] got z=%0b d=%0d required z=0 d=%0d", i, got_q[i][4], got_q[i][3:0], v[i]);
        end
      end
    end
  endtask

  task automatic test_sub();
    logic [3:0] v [3] = '{4'd3, 4'd14, 4'd0};
    exp_q.delete(); got_q.delete();
    res_ready = 1'b1;
    send(3'd0, 4'd3);
    send(3'd2, 4'd5);
    send(3'd2, 4'd14);
    wait_got(3);
    checks++;
    if (got_q.size() != 3) begin
      failures++;
      $display("FAIL sub_count got=%0d required=3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i] !== {(v[i] == 4'd0), v[i]}) begin
          failures++;
          $display("FAIL sub_result[%0d] got z=%0b d=%0d required z=%0b d=%0d", i, got_q[i][4], got_q[i][3:0], (v[i] == 4'd0), v[i]);
        end
      end
    end
  endtask

  task automatic test_shift_logic();
    logic [3:0] v [5] = '{4'd9, 4'd4, 4'd8, 4'd8, 4'd11};
    logic [8:0] f [4] = '{{5'b00000, 4'd9}, {5'b10000, 4'd4}, {5'b01000, 4'd8}, {5'b01100, 4'd8}};
    exp_q.delete(); got_q.delete(); alu_q.delete();
    res_ready = 1'b1;
    send(3'd0, 4'd9);
    send(3'd5, 4'd6);
    send(3'd6, 4'd1);
    send(3'd3, 4'd12);
    send(3'd4, 4'd3);
    wait_got(5);
    checks++;
    if (got_q.size() != 5 || alu_q.size() != 4) begin
      failures++;
      $display("FAIL shift_counts got results=%0d alu_cycles=%0d required 5 and 4", got_q.size(), alu_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got_q[i] !== {1'b0, v[i]}) begin
          failures++;
          $display("FAIL shift_result[%0d] got z=%0b d=%0d required z=0 d=%0d", i, got_q[i][4], got_q[i][3:0], v[i]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (alu_q[i] !== f[i]) begin
          failures++;
          $display("FAIL shift_alu[%0d] got f=%b a=%0d required f=%b a=%0d", i, alu_q[i][8:4], alu_q[i][3:0], f[i][8:4], f[i][3:0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [6] = '{3'd0, 3'd1, 3'd6, 3'd4, 3'd2, 3'd7};
    logic [3:0] ds  [6] = '{4'd1, 4'd2, 4'd0, 4'd8, 4'd4, 4'd0};
    logic [3:0] v   [5] = '{4'd1, 4'd3, 4'd6, 4'd14, 4'd10};
    int   n = 0;
    int   c5 = -1;
    logic took;
    exp_q.delete(); got_q.delete();
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cmd_op = ops[n];
      cmd_data = ds[n];
      took = cmd_ready;
      tick();
      if (took) begin
        n++;
        if (n == 5) begin
          c5 = c;
          checks++;
          if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ready_after_5th got=%0b required=0", cmd_ready);
          end
        end
        if (n == 6) break;
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (n != 5 || c5 != 4) begin
      failures++;
      $display("FAIL b2b_accepts got n=%0d last_cycle=%0d required n=5 last_cycle=4", n, c5);
    end
    checks++;
    if (res_valid !== 1'b1 || res_data !== 4'd1) begin
      failures++;
      $display("FAIL b2b_stall got v=%0b d=%0d required v=1 d=1", res_valid, res_data);
    end
    res_ready = 1'b1;
    wait_got(5);
    repeat (8) tick();
    checks++;
    if (got_q.size() != 5) begin
      failures++;
      $display("FAIL b2b_count got=%0d required=5", got_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got_q[i] !== {1'b0, v[i]}) begin
          failures++;
          $display("FAIL b2b_result[%0d] got z=%0b d=%0d required z=0 d=%0d", i, got_q[i][4], got_q[i][3:0], v[i]);
        end
      end
    end
  endtask

  task automatic test_full_refill();
    exp_q.delete(); got_q.delete();
    res_ready = 1'b0;
    send(3'd0, 4'd2);
    for (int i = 0; i < 4; i++) send(3'd1, 4'd1);
    checks++;
    if (cmd_ready !== 1'b0 || res_valid !== 1'b1) begin
      failures++;
      $display("FAIL full_state got rdy=%0b v=%0b required rdy=0 v=1", cmd_ready, res_valid);
    end
    cmd_op = 3'd1;
    cmd_data = 4'd1;
    cmd_valid = 1'b1;
    res_ready = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_release_ready got=%0b required=0", cmd_ready);
    end
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_after_pop_ready got=%0b required=1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_after_push_ready got=%0b required=0", cmd_ready);
    end
    wait_got(6);
    checks++;
    if (got_q.size() != 6) begin
      failures++;
      $display("FAIL full_count got=%0d required=6", got_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got_q[i] !== {1'b0, 4'(i + 2)}) begin
          failures++;
          $display("FAIL full_result[%0d] got z=%0b d=%0d required z=0 d=%0d", i, got_q[i][4], got_q[i][3:0], i + 2);
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    int k = 0;
    res_ready = 1'b0;
    send(3'd0, 4'd12);
    send(3'd1, 4'd1);
    send(3'd1, 4'd2);
    while (!res_valid && k < 20) begin
      tick();
      k++;
    end
    checks++;
    if (res_valid !== 1'b1 || res_data !== 4'd12) begin
      failures++;
      $display("FAIL rstin_hold got v=%0b d=%0d required v=1 d=12", res_valid, res_data);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({res_valid, res_data, res_zero, cmd_ready, alu_f, alu_a, alu_b} !==
        {1'b0, 4'h0, 1'b1, 1'b1, 5'h1f, 4'h0, 4'h0}) begin
      failures++;
      $display("FAIL rstin_outputs got v=%0b d=%0d z=%0b rdy=%0b f=%b a=%0d b=%0d required v=0 d=0 z=1 rdy=1 f=11111 a=0 b=0",
               res_valid, res_data, res_zero, cmd_ready, alu_f, alu_a, alu_b);
    end
    rst_n = 1'b1;
    res_ready = 1'b1;
    cmd_op = 3'd0;
    cmd_data = 4'd1;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || res_data !== 4'd0) begin
      failures++;
      $display("FAIL rstin_e0 got v=%0b d=%0d required v=0 d=0", res_valid, res_data);
    end
    tick();
    checks++;
    if (res_valid !== 1'b0 || res_data !== 4'd0) begin
      failures++;
      $display("FAIL rstin_e1 got v=%0b d=%0d required v=0 d=0", res_valid, res_data);
    end
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 4'd1 || res_zero !== 1'b0) begin
      failures++;
      $display("FAIL rstin_e2 got v=%0b d=%0d z=%0b required v=1 d=1 z=0", res_valid, res_data, res_zero);
    end
    repeat (10) tick();
    checks++;
    if (got_q.size() != 1 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstin_discard got results=%0d v=%0b required results=1 v=0", got_q.size(), res_valid);
    end else begin
      checks++;
      if (got_q[0] !== 5'b0_0001) begin
        failures++;
        $display("FAIL rstin_result got z=%0b d=%0d required z=0 d=1", got_q[0][4], got_q[0][3:0]);
      end
    end
  endtask

  task automatic test_random();
    int   sent = 0;
    int   cyc = 0;
    logic took;
    logic [2:0] op;
    logic [3:0] d;
    exp_q.delete(); got_q.delete();
    op = 3'($urandom_range(0, 7));
    d = 4'($urandom_range(0, 15));
    while (sent < 40 && cyc < 3000) begin
      cmd_op = op;
      cmd_data = d;
      cmd_valid = ($urandom_range(0, 3) != 0);
      res_ready = ($urandom_range(0, 2) != 0);
      took = cmd_valid && cmd_ready;
      tick();
      cyc++;
      if (took) begin
        sent++;
        op = 3'($urandom_range(0, 7));
        d = 4'($urandom_range(0, 15));
      end
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    checks++;
    if (sent != 40) begin
      failures++;
      $display("FAIL rand_sent got=%0d required=40", sent);
    end
    wait_got(exp_q.size());
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rand_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== {(exp_q[i] == 4'd0), exp_q[i]}) begin
          failures++;
          $display("FAIL rand_result[%0d] got z=%0b d=%0d required z=%0b d=%0d", i, got_q[i][4], got_q[i][3:0], (exp_q[i] == 4'd0), exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shift_logic();
    test_back_to_back();
    test_full_refill();
    test_reset_inflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
